// File: rtl/instr_fetch_if.sv
// naive_bus: simple request/grant bus shared by the fetch stage and its memory.
//   rd_req/rd_addr  master -> slave  read request and word address
//   rd_gnt          slave -> master  request accepted this cycle
//   rd_data         slave -> master  read data, valid the cycle after a grant
//   wr_req/wr_addr/wr_data           write side, driven by the master
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_data
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_data
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage. Owns the PC, issues word reads on a
// naive_bus, buffers returned words with their PC in a small FIFO and hands
// them to decode with a valid/ready handshake. Handles grant back-pressure
// and jump redirects.
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   bus                 naive_bus master (read side only; write side tied 0)
//   jump_en/jump_target redirect from execute; target low two bits ignored
//   instr_ready         decode accepts the head entry this cycle
//   instr_valid/instr/instr_pc  FIFO head towards decode
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    naive_bus.master    bus,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [63:0]   mem [BUF_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [63:0]   last_q;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          grant;
    logic [OW-1:0] occupancy;
    logic [OW-1:0] limit;

    always_comb begin
        empty       = (count == '0);
        full        = (count == CW'(BUF_DEPTH));
        instr_valid = !empty;
        // When empty, show the last head value rather than a stale slot.
        {instr_pc, instr} = empty ? last_q : mem[rd_ptr];
        pop         = instr_valid && instr_ready;
        // Credit check: count + inflight - pop < BUF_DEPTH, kept subtraction-free.
        occupancy   = OW'(count) + OW'(inflight);
        limit       = OW'(BUF_DEPTH) + OW'(pop);
        bus.rd_req  = !rst && !jump_en && (occupancy < limit);
        bus.rd_addr = rst ? '0 : pc;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        grant       = bus.rd_req && bus.rd_gnt;
        // A redirect kills the response of an access granted last cycle.
        push        = inflight && !jump_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            last_q      <= '0;
        end else begin
            inflight <= grant;
            if (grant) begin
                inflight_pc <= pc;
            end
            if (!empty) begin
                last_q <= mem[rd_ptr];
            end
            if (jump_en) begin
                // Redirect wins over pop and push: flush everything.
                pc     <= jump_target & ~32'h3;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {inflight_pc, bus.rd_data};
        end
    end

    // The credit rule guarantees a push never lands in a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: ROM slave model, directed scenarios, then
// randomized ready/grant/jump traffic checked by an in-order scoreboard.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    naive_bus bus ();

    instr_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned beats  = 0;

    // ROM contents: a few fixed words, a pattern elsewhere, 0 beyond 0x148.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00006e33;
            32'h0000_0004: return 32'h000062b3;
            32'h0000_0008: return 32'h000302b7;
            32'h0000_0010: return 32'h00628023;
            32'h0000_0144: return 32'hec1ff06f;
            default:       return (a < 32'h148) ? {a[15:0] ^ 16'hA5C3, ~a[15:0]} : 32'h0;
        endcase
    endfunction

    // Slave: granted request in cycle N returns data in N+1, otherwise 0.
    always @(posedge clk) begin
        bus.rd_data <= (bus.rd_req && bus.rd_gnt) ? rom(bus.rd_addr) : 32'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: program-order stream of (pc, word) from the latest start PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t sb_q[$];

    task automatic extend_stream(input int unsigned n);
        logic [31:0] p;
        for (int unsigned i = 0; i < n; i++) begin
            p = sb_q[$].pc + 32'd4;
            sb_q.push_back('{pc: p, word: rom(p)});
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        logic [31:0] s;
        s = start & ~32'h3;
        sb_q.delete();
        sb_q.push_back('{pc: s, word: rom(s)});
        extend_stream(15);
    endtask

    // Monitor: compares every accepted beat and checks hold stability.
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && instr_valid) begin
                check("hold_pc", instr_pc, hold_pc);
                check("hold_instr", instr, hold_instr);
            end
            if (instr_valid && instr_ready && !jump_en) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: got beat pc %h expected none", instr_pc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", instr_pc, e.pc);
                    check("sb_instr", instr, e.word);
                    beats++;
                    if (sb_q.size() < 8) extend_stream(8);
                end
            end
            hold_v     = instr_valid && !instr_ready && !jump_en;
            hold_pc    = instr_pc;
            hold_instr = instr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at a drive point; returns at the drive point of R+1.
    task automatic do_jump(input logic [31:0] t);
        jump_en     = 1'b1;
        jump_target = t;
        @(posedge clk);
        restart_stream(t);
        #1;
        jump_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b0;
        rst = 1'b1; jump_en = 1'b0; jump_target = '0; instr_ready = 1'b0; bus.rd_gnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_req", bus.rd_req, 0);
        check("rst_addr", bus.rd_addr, 0);
        check("rst_wr_req", bus.wr_req, 0);

        // Scenario 1: release, first grant in N, valid from N+2, back-to-back.
        @(posedge clk); #1;
        rst = 1'b0; instr_ready = 1'b1; bus.rd_gnt = 1'b1;
        restart_stream(RESET_PC);
        @(negedge clk);
        check("t1_req", bus.rd_req, 1);
        check("t1_addr", bus.rd_addr, RESET_PC);
        check("t1_valid_n", instr_valid, 0);
        cyc(); @(negedge clk);
        check("t1_valid_n1", instr_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); @(negedge clk);
            check("t1_stream_valid", instr_valid, 1);
        end
        cyc();

        // Scenario 2: decode stall for 5 cycles.
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_valid", instr_valid, 1);
            if (i > 0) check("t2_req_low", bus.rd_req, 0);
            cyc();
        end
        instr_ready = 1'b1;
        repeat (4) cyc();

        // Scenario 3: grant withheld 3 cycles at pc 0x10.
        bus.rd_gnt = 1'b0;
        do_jump(32'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_req", bus.rd_req, 1);
            check("t3_addr", bus.rd_addr, 32'h10);
            check("t3_valid", instr_valid, 0);
            cyc();
        end
        bus.rd_gnt = 1'b1;
        repeat (6) cyc();

        // Scenario 4: jump to 0x145 with the FIFO holding stale words.
        instr_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("t4_full_valid", instr_valid, 1);
        check("t4_full_req", bus.rd_req, 0);
        #4;
        do_jump(32'h145);
        instr_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_r1", instr_valid, 0);
        check("t4_addr_r1", bus.rd_addr, 32'h144);
        cyc(); @(negedge clk);
        check("t4_valid_r2", instr_valid, 0);
        cyc(); @(negedge clk);
        check("t4_valid_r3", instr_valid, 1);
        check("t4_pc_r3", instr_pc, 32'h144);
        check("t4_instr_r3", instr, 32'hec1ff06f);
        cyc(); @(negedge clk);
        check("t4_pc_r4", instr_pc, 32'h148);
        check("t4_instr_r4", instr, 32'h0);
        repeat (2) cyc();

        // Scenario 5: jump coincident with pop and response; then back-to-back jumps.
        do_jump(32'h0);
        repeat (4) cyc();
        @(negedge clk);
        check("t5_pre_valid", instr_valid, 1);
        #4;
        do_jump(32'h20);
        @(negedge clk);
        check("t5_valid_r1", instr_valid, 0);
        cyc(); @(negedge clk);
        check("t5_valid_r2", instr_valid, 0);
        cyc(); @(negedge clk);
        check("t5_pc_r3", instr_pc, 32'h20);
        #4;
        do_jump(32'h40);
        do_jump(32'h80);
        cyc(); cyc(); @(negedge clk);
        check("t5_b2b_pc", instr_pc, 32'h80);
        #4;

        // Wrap: 0xFFFFFFF8 streams into 0x0.
        do_jump(32'hFFFF_FFF8);
        repeat (8) cyc();

        // Scenario 6: asynchronous reset mid-stream with an access in flight.
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", instr_valid, 0);
        check("t6_instr", instr, 0);
        check("t6_pc", instr_pc, 0);
        check("t6_req", bus.rd_req, 0);
        check("t6_addr", bus.rd_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        restart_stream(RESET_PC);
        @(negedge clk);
        check("t6_restart_addr", bus.rd_addr, RESET_PC);
        cyc(); cyc(); @(negedge clk);
        check("t6_restart_valid", instr_valid, 1);
        check("t6_restart_pc", instr_pc, RESET_PC);
        #4;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            bus.rd_gnt  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 4) == 0) do_jump(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                else do_jump(32'($urandom_range(0, 32'h150)));
            end else begin
                cyc();
            end
        end

        // Drain: with full throughput the stream must keep moving.
        instr_ready = 1'b1;
        bus.rd_gnt  = 1'b1;
        b0 = beats;
        repeat (10) cyc();
        check("drain_progress", 32'(beats >= b0 + 7), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
